bus_master_ctrl: RTL and testbench

//  Master-side bus sequencer that lets a client (CPU fetch/mem stage, DMA) take part in the 4-master shared bus.

---
 rtl/bus_master_ctrl_pkg.sv | 20 ++
 rtl/bus_master_ctrl_if.sv | 34 +++
 rtl/bus_master_ctrl_timer.sv | 34 +++
 rtl/bus_master_ctrl.sv | 178 +++++++++++++++++
 tb/tb_bus_master_ctrl.sv | 276 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/bus_master_ctrl_pkg.sv
// Shared definitions for the bus master sequencer.
//  - bus_if_state_e : sequencer state encoding (2 bits)
//  - TMO_W          : width of the access watchdog counter
//  - READ / ENABLE_ / DISABLE_ : bus-level constants (active-low strobes)
package bus_master_ctrl_pkg;

  typedef enum logic [1:0] {
    BUS_IF_IDLE   = 2'd0,
    BUS_IF_REQ    = 2'd1,
    BUS_IF_ACCESS = 2'd2,
    BUS_IF_WAIT   = 2'd3
  } bus_if_state_e;

  localparam int   TMO_W    = 8;

  localparam logic READ     = 1'b1;
  localparam logic ENABLE_  = 1'b0;
  localparam logic DISABLE_ = 1'b1;

endpackage

// File: rtl/bus_master_ctrl_if.sv
// Master-side connection to the shared bus (one per master, maps to mN_*).
//  m_req_    master -> bus  request, active low
//  m_grnt_   bus -> master  grant, active low
//  m_addr    master -> bus  word address
//  m_as_     master -> bus  address strobe, active low
//  m_rw      master -> bus  1 = READ, 0 = WRITE
//  m_wr_data master -> bus  write data
//  m_rd_data bus -> master  shared slave read data
//  m_rdy_    bus -> master  slave ready, active low
interface bus_master_ctrl_if #(
  parameter int ADDR_W = 30,
  parameter int DATA_W = 32
);

  logic              m_req_;
  logic              m_grnt_;
  logic [ADDR_W-1:0] m_addr;
  logic              m_as_;
  logic              m_rw;
  logic [DATA_W-1:0] m_wr_data;
  logic [DATA_W-1:0] m_rd_data;
  logic              m_rdy_;

  modport master (
    output m_req_, m_addr, m_as_, m_rw, m_wr_data,
    input  m_grnt_, m_rd_data, m_rdy_
  );

  modport slave (
    input  m_req_, m_addr, m_as_, m_rw, m_wr_data,
    output m_grnt_, m_rd_data, m_rdy_
  );

endinterface

// File: rtl/bus_master_ctrl_timer.sv
// Access watchdog counter: clear / increment / saturate, with terminal count.
//  clk, reset  clock and asynchronous active-high reset
//  clr         force count to zero (wins over inc)
//  inc         advance count by one, holding at all-ones
//  tc          count equals TMO_CYC
module bus_master_ctrl_timer
  import bus_master_ctrl_pkg::*;
#(
  parameter int TMO_CYC = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic inc,
  output logic tc
);

  logic [TMO_W-1:0] count;

  // Saturation keeps the equality compare in tc from ever being revisited
  // by a wrapped count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

  assign tc = (count == TMO_W'(TMO_CYC));

endmodule

// File: rtl/bus_master_ctrl.sv
// Master-side bus sequencer: turns one-word client read/write commands into
// the shared-bus handshake (req_/grnt_, one-cycle as_, wait for rdy_) and
// returns completion and read data. A watchdog aborts accesses whose rdy_
// never arrives.
//  clk, reset     clock, asynchronous active-high reset
//  cpu_req        command valid, sampled in IDLE only
//  cpu_rw         1 = READ, 0 = WRITE
//  cpu_addr       word address
//  cpu_wr_data    write data
//  cpu_flush      cancel a command still waiting for grant
//  cpu_busy       command outstanding
//  cpu_done       one-cycle completion pulse
//  cpu_err        one-cycle timeout pulse, coincident with cpu_done
//  cpu_rd_data    data captured at completion, held until the next one
//  bus            master modport of the shared bus
module bus_master_ctrl
  import bus_master_ctrl_pkg::*;
#(
  parameter int ADDR_W  = 30,
  parameter int DATA_W  = 32,
  parameter int TMO_CYC = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_rw,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wr_data,
  input  logic              cpu_flush,
  output logic              cpu_busy,
  output logic              cpu_done,
  output logic              cpu_err,
  output logic [DATA_W-1:0] cpu_rd_data,
  bus_master_ctrl_if.master bus
);

  bus_if_state_e     state, state_nxt;

  logic              req_q,   req_nxt;
  logic              as_q,    as_nxt;
  logic              rw_q,    rw_nxt;
  logic [ADDR_W-1:0] addr_q,  addr_nxt;
  logic [DATA_W-1:0] wdata_q, wdata_nxt;
  logic              busy_q,  busy_nxt;
  logic              done_q,  done_nxt;
  logic              err_q,   err_nxt;
  logic [DATA_W-1:0] rdata_q, rdata_nxt;

  logic              tmr_clr, tmr_inc, tmr_tc;

  bus_master_ctrl_timer #(
    .TMO_CYC (TMO_CYC)
  ) u_timer (
    .clk   (clk),
    .reset (reset),
    .clr   (tmr_clr),
    .inc   (tmr_inc),
    .tc    (tmr_tc)
  );

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= BUS_IF_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      BUS_IF_IDLE: begin
        if (cpu_req) state_nxt = BUS_IF_REQ;
      end
      BUS_IF_REQ: begin
        // Flush beats a grant arriving in the same cycle.
        if (cpu_flush)                  state_nxt = BUS_IF_IDLE;
        else if (bus.m_grnt_ == ENABLE_) state_nxt = BUS_IF_ACCESS;
      end
      BUS_IF_ACCESS: begin
        // A zero-wait slave may answer during the strobe cycle itself.
        if (bus.m_rdy_ == ENABLE_) state_nxt = BUS_IF_IDLE;
        else                       state_nxt = BUS_IF_WAIT;
      end
      BUS_IF_WAIT: begin
        if ((bus.m_rdy_ == ENABLE_) || tmr_tc) state_nxt = BUS_IF_IDLE;
      end
      default: state_nxt = BUS_IF_IDLE;
    endcase
  end

  // Output logic: next values of the registered outputs
  always_comb begin
    req_nxt   = req_q;
    as_nxt    = DISABLE_;
    rw_nxt    = rw_q;
    addr_nxt  = addr_q;
    wdata_nxt = wdata_q;
    done_nxt  = 1'b0;
    err_nxt   = 1'b0;
    rdata_nxt = rdata_q;
    tmr_clr   = 1'b0;
    tmr_inc   = 1'b0;
    case (state)
      BUS_IF_IDLE: begin
        if (cpu_req) begin
          req_nxt   = ENABLE_;
          rw_nxt    = cpu_rw;
          addr_nxt  = cpu_addr;
          wdata_nxt = cpu_wr_data;
        end
      end
      BUS_IF_REQ: begin
        if (cpu_flush) begin
          req_nxt = DISABLE_;
        end else if (bus.m_grnt_ == ENABLE_) begin
          as_nxt  = ENABLE_;
          tmr_clr = 1'b1;
        end
      end
      BUS_IF_ACCESS, BUS_IF_WAIT: begin
        // The timer counts from the strobe cycle, so it reads TMO_CYC in the
        // TMO_CYC-th WAIT cycle; success is checked first so a late rdy_
        // coinciding with the timeout still completes cleanly.
        tmr_inc = 1'b1;
        if (bus.m_rdy_ == ENABLE_) begin
          rdata_nxt = bus.m_rd_data;
          done_nxt  = 1'b1;
          req_nxt   = DISABLE_;
        end else if ((state == BUS_IF_WAIT) && tmr_tc) begin
          done_nxt  = 1'b1;
          err_nxt   = 1'b1;
          req_nxt   = DISABLE_;
        end
      end
      default: ;
    endcase
  end

  assign busy_nxt = (state_nxt != BUS_IF_IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      req_q   <= DISABLE_;
      as_q    <= DISABLE_;
      rw_q    <= READ;
      addr_q  <= '0;
      wdata_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      req_q   <= req_nxt;
      as_q    <= as_nxt;
      rw_q    <= rw_nxt;
      addr_q  <= addr_nxt;
      wdata_q <= wdata_nxt;
      busy_q  <= busy_nxt;
      done_q  <= done_nxt;
      err_q   <= err_nxt;
      rdata_q <= rdata_nxt;
    end
  end

  assign bus.m_req_    = req_q;
  assign bus.m_as_     = as_q;
  assign bus.m_rw      = rw_q;
  assign bus.m_addr    = addr_q;
  assign bus.m_wr_data = wdata_q;
  assign cpu_busy      = busy_q;
  assign cpu_done      = done_q;
  assign cpu_err       = err_q;
  assign cpu_rd_data   = rdata_q;

endmodule

// File: tb/tb_bus_master_ctrl.sv
// Bench for bus_master_ctrl. The expected completion cycle, error flag and
// read data of each transaction are derived from its grant delay, slave
// ready delay and the watchdog limit.
module tb_bus_master_ctrl;

  localparam int AW  = 30;
  localparam int DW  = 32;
  localparam int TMO = 4;
  localparam int NEVER = 7;   // ready delay beyond the watchdog limit

  logic          clk = 1'b0;
  logic          reset;
  logic          cpu_req;
  logic          cpu_rw;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wr_data;
  logic          cpu_flush;
  logic          cpu_busy;
  logic          cpu_done;
  logic          cpu_err;
  logic [DW-1:0] cpu_rd_data;

  bus_master_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) bus_if ();

  bus_master_ctrl #(
    .ADDR_W  (AW),
    .DATA_W  (DW),
    .TMO_CYC (TMO)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .cpu_req     (cpu_req),
    .cpu_rw      (cpu_rw),
    .cpu_addr    (cpu_addr),
    .cpu_wr_data (cpu_wr_data),
    .cpu_flush   (cpu_flush),
    .cpu_busy    (cpu_busy),
    .cpu_done    (cpu_done),
    .cpu_err     (cpu_err),
    .cpu_rd_data (cpu_rd_data),
    .bus         (bus_if)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference state: command currently on the bus and last completed data.
  logic          exp_rw;
  logic [AW-1:0] exp_addr;
  logic [DW-1:0] exp_wdata;
  logic [DW-1:0] exp_rd;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_cmd(input string tag);
    chk({tag, "_addr"},  64'(bus_if.m_addr),    64'(exp_addr));
    chk({tag, "_rw"},    64'(bus_if.m_rw),      64'(exp_rw));
    chk({tag, "_wdata"}, 64'(bus_if.m_wr_data), 64'(exp_wdata));
  endtask

  task automatic issue(input logic rw, input logic [AW-1:0] a, input logic [DW-1:0] d);
    cpu_req     = 1'b1;
    cpu_rw      = rw;
    cpu_addr    = a;
    cpu_wr_data = d;
    exp_rw      = rw;
    exp_addr    = a;
    exp_wdata   = d;
  endtask

  // Called at the negedge of the cycle in which the command was presented.
  // gd: REQ cycles before grant; r: cycles after the strobe cycle at which
  // rdy_ pulses (0 = during the strobe). Completion comes one cycle after
  // rdy_, or TMO+1 cycles after the strobe if rdy_ is later than TMO.
  task automatic run_txn(input int gd, input int r, input logic [DW-1:0] sd,
                         input bit chain, input logic nrw,
                         input logic [AW-1:0] na, input logic [DW-1:0] nd);
    int ek;
    bit e;
    ek = (r <= TMO) ? r + 1 : TMO + 1;
    e  = (r > TMO);
    @(negedge clk);
    cpu_req     = 1'b0;
    cpu_addr    = AW'($urandom);
    cpu_wr_data = $urandom;
    chk("req_low", 64'(bus_if.m_req_), 64'(0));
    chk("req_busy", 64'(cpu_busy), 64'(1));
    chk("req_as", 64'(bus_if.m_as_), 64'(1));
    chk_cmd("req");
    for (int i = 0; i < gd; i++) begin
      @(negedge clk);
      chk("gwait_req", 64'(bus_if.m_req_), 64'(0));
      chk("gwait_as", 64'(bus_if.m_as_), 64'(1));
      chk("gwait_done", 64'(cpu_done), 64'(0));
    end
    bus_if.m_grnt_ = 1'b0;
    @(negedge clk);
    chk("as_low", 64'(bus_if.m_as_), 64'(0));
    chk("as_done", 64'(cpu_done), 64'(0));
    chk_cmd("as");
    bus_if.m_rdy_     = (r == 0) ? 1'b0 : 1'b1;
    bus_if.m_rd_data  = (r == 0) ? sd : $urandom;
    for (int k = 1; k <= ek; k++) begin
      @(negedge clk);
      if (k < ek) begin
        chk("wait_as", 64'(bus_if.m_as_), 64'(1));
        chk("wait_done", 64'(cpu_done), 64'(0));
        chk("wait_busy", 64'(cpu_busy), 64'(1));
        chk_cmd("wait");
        bus_if.m_rdy_    = (k == r) ? 1'b0 : 1'b1;
        bus_if.m_rd_data = (k == r) ? sd : $urandom;
        cpu_flush        = 1'($urandom_range(0, 1));
      end else begin
        if (!e) exp_rd = sd;
        chk("done", 64'(cpu_done), 64'(1));
        chk("done_err", 64'(cpu_err), 64'(e));
        chk("done_rdata", 64'(cpu_rd_data), 64'(exp_rd));
        chk("done_req_high", 64'(bus_if.m_req_), 64'(1));
        chk("done_busy", 64'(cpu_busy), 64'(0));
        chk("done_as", 64'(bus_if.m_as_), 64'(1));
        bus_if.m_rdy_  = 1'b1;
        bus_if.m_grnt_ = 1'b1;
        cpu_flush      = 1'b0;
      end
    end
    if (chain) begin
      issue(nrw, na, nd);
    end else begin
      @(negedge clk);
      chk("post_done", 64'(cpu_done), 64'(0));
      chk("post_busy", 64'(cpu_busy), 64'(0));
      chk("post_req", 64'(bus_if.m_req_), 64'(1));
    end
  endtask

  initial begin
    reset            = 1'b1;
    cpu_req          = 1'b0;
    cpu_rw           = 1'b1;
    cpu_addr         = '0;
    cpu_wr_data      = '0;
    cpu_flush        = 1'b0;
    bus_if.m_grnt_   = 1'b1;
    bus_if.m_rdy_    = 1'b1;
    bus_if.m_rd_data = '0;
    exp_rd           = '0;

    // Reset values before any clock edge
    #2;
    chk("rst_req", 64'(bus_if.m_req_), 64'(1));
    chk("rst_as", 64'(bus_if.m_as_), 64'(1));
    chk("rst_rw", 64'(bus_if.m_rw), 64'(1));
    chk("rst_addr", 64'(bus_if.m_addr), 64'(0));
    chk("rst_wdata", 64'(bus_if.m_wr_data), 64'(0));
    chk("rst_busy", 64'(cpu_busy), 64'(0));
    chk("rst_done", 64'(cpu_done), 64'(0));
    chk("rst_err", 64'(cpu_err), 64'(0));
    chk("rst_rdata", 64'(cpu_rd_data), 64'(0));
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Read, grant two cycles after request, rdy_ one cycle after strobe
    issue(1'b1, 30'h2A5_5A5A, 32'h0);
    run_txn(1, 1, 32'hDEADBEEF, 1'b0, 1'b0, '0, '0);

    // Write with zero-wait slave; read data captured on writes too
    issue(1'b0, 30'h100, 32'h12345678);
    run_txn(0, 0, 32'hCAFE0001, 1'b0, 1'b0, '0, '0);

    // Flush while waiting for grant
    issue(1'b1, 30'h55, 32'h0);
    @(negedge clk);
    cpu_req   = 1'b0;
    chk("fl1_req", 64'(bus_if.m_req_), 64'(0));
    cpu_flush = 1'b1;
    @(negedge clk);
    chk("fl1_req_high", 64'(bus_if.m_req_), 64'(1));
    chk("fl1_busy", 64'(cpu_busy), 64'(0));
    chk("fl1_done", 64'(cpu_done), 64'(0));
    cpu_flush = 1'b0;
    @(negedge clk);
    chk("fl1_done2", 64'(cpu_done), 64'(0));
    chk("fl1_as", 64'(bus_if.m_as_), 64'(1));

    // Flush and grant in the same cycle: flush wins, no strobe
    issue(1'b0, 30'h66, 32'h77);
    @(negedge clk);
    cpu_req        = 1'b0;
    cpu_flush      = 1'b1;
    bus_if.m_grnt_ = 1'b0;
    @(negedge clk);
    chk("fl2_req_high", 64'(bus_if.m_req_), 64'(1));
    chk("fl2_busy", 64'(cpu_busy), 64'(0));
    chk("fl2_as", 64'(bus_if.m_as_), 64'(1));
    chk("fl2_done", 64'(cpu_done), 64'(0));
    cpu_flush      = 1'b0;
    bus_if.m_grnt_ = 1'b1;
    @(negedge clk);
    chk("fl2_as2", 64'(bus_if.m_as_), 64'(1));
    chk("fl2_done2", 64'(cpu_done), 64'(0));

    // Timeout: no rdy_, read data must stay as before; then a normal access
    issue(1'b1, 30'h3FF, 32'h0);
    run_txn(0, NEVER, 32'hBAD0BAD0, 1'b0, 1'b0, '0, '0);
    issue(1'b1, 30'h400, 32'h0);
    run_txn(2, 2, 32'h0F0F1234, 1'b0, 1'b0, '0, '0);

    // rdy_ arriving exactly at the watchdog limit: success, no error
    issue(1'b0, 30'h401, 32'h9);
    run_txn(1, TMO, 32'hA5A5A5A5, 1'b0, 1'b0, '0, '0);

    // Back-to-back with cpu_req held across done
    issue(1'b1, 30'h10, 32'h0);
    run_txn(1, 0, 32'h11111111, 1'b1, 1'b0, 30'h20, 32'h22222222);
    run_txn(0, 3, 32'h33333333, 1'b0, 1'b0, '0, '0);

    // Reset asserted during WAIT, away from a clock edge
    issue(1'b1, 30'h77, 32'h0);
    @(negedge clk);
    cpu_req        = 1'b0;
    bus_if.m_grnt_ = 1'b0;
    @(negedge clk);
    chk("rw_as_low", 64'(bus_if.m_as_), 64'(0));
    @(negedge clk);
    chk("rw_wait_busy", 64'(cpu_busy), 64'(1));
    #2;
    reset = 1'b1;
    #1;
    exp_rd = '0;
    chk("rw_req", 64'(bus_if.m_req_), 64'(1));
    chk("rw_as", 64'(bus_if.m_as_), 64'(1));
    chk("rw_busy", 64'(cpu_busy), 64'(0));
    chk("rw_done", 64'(cpu_done), 64'(0));
    chk("rw_rdata", 64'(cpu_rd_data), 64'(exp_rd));
    @(negedge clk);
    chk("rw_done2", 64'(cpu_done), 64'(0));
    reset          = 1'b0;
    bus_if.m_grnt_ = 1'b1;
    @(negedge clk);
    chk("rw_done3", 64'(cpu_done), 64'(0));
    chk("rw_busy3", 64'(cpu_busy), 64'(0));

    // Randomized transactions, some chained back-to-back
    begin
      bit pending;
      bit ch;
      pending = 1'b0;
      for (int i = 0; i < 24; i++) begin
        logic          nrw;
        logic [AW-1:0] na;
        logic [DW-1:0] nd;
        if (!pending) issue(1'($urandom_range(0, 1)), AW'($urandom), $urandom);
        nrw = 1'($urandom_range(0, 1));
        na  = AW'($urandom);
        nd  = $urandom;
        ch  = (i < 23) ? 1'($urandom_range(0, 1)) : 1'b0;
        run_txn(int'($urandom_range(0, 3)), int'($urandom_range(0, 6)),
                $urandom, ch, nrw, na, nd);
        pending = ch;
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
